// File: rtl/xform_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : xform_scheduler
//  Description : Frame-level sequencer for the coordinate transformation
//                pipeline. Latches a config snapshot on start, raster-scans
//                source coordinates one per cycle (honouring stall), tracks
//                in-flight samples through the fixed pipeline latency and
//                pulses done once the last sample has left the pipeline.
//                Optional feature macro: XFORM_SCHED_ABORT_EN (adds the
//                abort input that ends the scan early).
//  Revision    : 1.0 - initial release
// ============================================================================
module xform_scheduler #(
    parameter int LATENCY = 5,
    parameter int CW      = 8
) (
    input  logic          ACLK,
    input  logic          ARESET,
    input  logic          start,
`ifdef XFORM_SCHED_ABORT_EN
    input  logic          abort,
`endif
    input  logic          stall,
    input  logic [CW-1:0] cfg_xcenter,
    input  logic [CW-1:0] cfg_ycenter,
    input  logic [CW-1:0] cfg_zoom,
    input  logic [CW-1:0] cfg_angle,
    input  logic [CW-1:0] cfg_xmax,
    input  logic [CW-1:0] cfg_ymax,
    output logic [CW-1:0] Xcoord,
    output logic [CW-1:0] Ycoord,
    output logic [CW-1:0] Xcenter,
    output logic [CW-1:0] Ycenter,
    output logic [CW-1:0] Zoom,
    output logic [CW-1:0] Angle,
    output logic          issue_valid,
    output logic          pix_valid,
    output logic          busy,
    output logic          done,
    output logic [15:0]   pixel_count
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LOAD  = 3'd1;
    localparam logic [2:0] c_ST_SCAN  = 3'd2;
    localparam logic [2:0] c_ST_DRAIN = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [CW-1:0]      r_x;
    logic [CW-1:0]      r_y;
    logic [CW-1:0]      r_xmax;
    logic [CW-1:0]      r_ymax;
    logic [CW-1:0]      r_xout;
    logic [CW-1:0]      r_yout;
    logic [CW-1:0]      r_xcenter;
    logic [CW-1:0]      r_ycenter;
    logic [CW-1:0]      r_zoom;
    logic [CW-1:0]      r_angle;
    logic [15:0]        r_pixel_count;
    logic [LATENCY-1:0] r_inflight;
    logic [LATENCY-1:0] w_inflight_next;
    logic               w_issue;
    logic               w_last;
    logic               w_abort;

`ifdef XFORM_SCHED_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Issue only while scanning and downstream is not pushing back.
    assign w_issue = (r_state == c_ST_SCAN) && !stall;
    assign w_last  = (r_x == r_xmax) && (r_y == r_ymax);

    // The in-flight tracker advances every cycle; the pipeline never stalls.
    assign w_inflight_next = (r_inflight << 1) | LATENCY'(w_issue);

    // Next-state logic; DRAIN exits when the tracker will be empty next cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (start) w_state_next = c_ST_LOAD;
            c_ST_LOAD:  w_state_next = w_abort ? c_ST_DRAIN : c_ST_SCAN;
            c_ST_SCAN:  if (w_abort || (w_issue && w_last)) w_state_next = c_ST_DRAIN;
            c_ST_DRAIN: if (w_inflight_next == '0) w_state_next = c_ST_DONE;
            c_ST_DONE:  w_state_next = c_ST_IDLE;
            default:    w_state_next = c_ST_IDLE;
        endcase
    end

    // State register and in-flight shift register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state    <= c_ST_IDLE;
            r_inflight <= '0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= w_inflight_next;
        end
    end

    // Config snapshot, raster counters, last-issued coordinate and count.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_x           <= '0;
            r_y           <= '0;
            r_xmax        <= '0;
            r_ymax        <= '0;
            r_xout        <= '0;
            r_yout        <= '0;
            r_xcenter     <= '0;
            r_ycenter     <= '0;
            r_zoom        <= '0;
            r_angle       <= '0;
            r_pixel_count <= '0;
        end else begin
            if (r_state == c_ST_IDLE && start) begin
                r_pixel_count <= '0;
            end
            if (r_state == c_ST_LOAD) begin
                r_xcenter <= cfg_xcenter;
                r_ycenter <= cfg_ycenter;
                r_zoom    <= cfg_zoom;
                r_angle   <= cfg_angle;
                r_xmax    <= cfg_xmax;
                r_ymax    <= cfg_ymax;
                r_x       <= '0;
                r_y       <= '0;
            end
            if (w_issue) begin
                r_xout        <= r_x;
                r_yout        <= r_y;
                r_pixel_count <= r_pixel_count + 16'd1;
                if (r_x == r_xmax) begin
                    r_x <= '0;
                    r_y <= r_y + CW'(1);
                end else begin
                    r_x <= r_x + CW'(1);
                end
            end
        end
    end

    // Coordinates show the live counter on an issue and otherwise hold.
    assign Xcoord      = w_issue ? r_x : r_xout;
    assign Ycoord      = w_issue ? r_y : r_yout;
    assign Xcenter     = r_xcenter;
    assign Ycenter     = r_ycenter;
    assign Zoom        = r_zoom;
    assign Angle       = r_angle;
    assign issue_valid = w_issue;
    assign pix_valid   = r_inflight[LATENCY-1];
    assign busy        = (r_state == c_ST_LOAD) || (r_state == c_ST_SCAN) ||
                         (r_state == c_ST_DRAIN);
    assign done        = (r_state == c_ST_DONE);
    assign pixel_count = r_pixel_count;

endmodule
`default_nettype wire

// File: tb/tb_xform_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xform_scheduler
//  Description : Randomized self-checking bench for xform_scheduler. A
//                timeline model predicts issue order, pix_valid, busy,
//                done and counts for each frame. Abort scenarios are
//                exercised when XFORM_SCHED_ABORT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xform_scheduler;

    localparam int L  = 5;
    localparam int CW = 8;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic          start;
    logic          stall;
`ifdef XFORM_SCHED_ABORT_EN
    logic          abort;
`endif
    logic [CW-1:0] cfg_xcenter, cfg_ycenter, cfg_zoom, cfg_angle, cfg_xmax, cfg_ymax;
    logic [CW-1:0] Xcoord, Ycoord, Xcenter, Ycenter, Zoom, Angle;
    logic          issue_valid, pix_valid, busy, done;
    logic [15:0]   pixel_count;

    int            total = 0;
    int            bad   = 0;
    logic [CW-1:0] last_x = '0;
    logic [CW-1:0] last_y = '0;

    xform_scheduler #(.LATENCY(L), .CW(CW)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .start       (start),
`ifdef XFORM_SCHED_ABORT_EN
        .abort       (abort),
`endif
        .stall       (stall),
        .cfg_xcenter (cfg_xcenter),
        .cfg_ycenter (cfg_ycenter),
        .cfg_zoom    (cfg_zoom),
        .cfg_angle   (cfg_angle),
        .cfg_xmax    (cfg_xmax),
        .cfg_ymax    (cfg_ymax),
        .Xcoord      (Xcoord),
        .Ycoord      (Ycoord),
        .Xcenter     (Xcenter),
        .Ycenter     (Ycenter),
        .Zoom        (Zoom),
        .Angle       (Angle),
        .issue_valid (issue_valid),
        .pix_valid   (pix_valid),
        .busy        (busy),
        .done        (done),
        .pixel_count (pixel_count)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at time %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_xc"},  32'(Xcoord), 32'(0));
        check({tag, "_yc"},  32'(Ycoord), 32'(0));
        check({tag, "_xce"}, 32'(Xcenter), 32'(0));
        check({tag, "_yce"}, 32'(Ycenter), 32'(0));
        check({tag, "_zm"},  32'(Zoom), 32'(0));
        check({tag, "_an"},  32'(Angle), 32'(0));
        check({tag, "_iv"},  32'(issue_valid), 32'(0));
        check({tag, "_pv"},  32'(pix_valid), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_done"}, 32'(done), 32'(0));
        check({tag, "_cnt"}, 32'(pixel_count), 32'(0));
    endtask

    // One frame, cycle numbering: start driven in cycle 0 (sampled at edge 0).
    // Model: issues follow row-major order, one per non-stalled scan cycle;
    // the scan closes after the last issue or an abort in cycle a, and done
    // lands at max(a+2, last_issue+L+1).
    task automatic run_frame(input int xm, input int ym, input int stall_pct,
                             input int st_lo, input int st_hi, input int abort_cyc,
                             input int rst_cyc, input logic [CW-1:0] ang0,
                             input int exp_d, input int exp_n);
        int            n, k, n_iss, last_iss, d, c, obs_d;
        bit            open, ei, ep, eb;
        bit            hist [0:1023];
        logic [CW-1:0] qx[$], qy[$];
        logic [CW-1:0] s_xc, s_yc, s_zm, s_an;
        n = (xm + 1) * (ym + 1);
        for (int y = 0; y <= ym; y++)
            for (int x = 0; x <= xm; x++) begin
                qx.push_back(CW'(x));
                qy.push_back(CW'(y));
            end
        foreach (hist[i]) hist[i] = 1'b0;
        k = 0; n_iss = 0; last_iss = -1; d = -1; obs_d = -1; open = 1'b1;

        @(posedge ACLK); #1;
        c           = 0;
        ARESET      = 1'b0;
        start       = 1'b1;
        stall       = 1'($urandom_range(1));
        cfg_xcenter = CW'($urandom);
        cfg_ycenter = CW'($urandom);
        cfg_zoom    = CW'($urandom);
        cfg_angle   = ang0;
        cfg_xmax    = CW'(xm);
        cfg_ymax    = CW'(ym);
        s_xc = cfg_xcenter; s_yc = cfg_ycenter; s_zm = cfg_zoom; s_an = cfg_angle;
`ifdef XFORM_SCHED_ABORT_EN
        abort = 1'b0;
`endif
        forever begin
            @(negedge ACLK);
            if (rst_cyc >= 0 && c == rst_cyc + 1) begin
                last_x = '0;
                last_y = '0;
                check_all_zero("after_reset");
                break;
            end
            ei = (c >= 2) && open && !stall;
            ep = (c >= L) && hist[c - L];
            eb = (c >= 1) && (d < 0 || c < d);
            check("issue_valid", 32'(issue_valid), 32'(ei));
            check("pix_valid", 32'(pix_valid), 32'(ep));
            check("busy", 32'(busy), 32'(eb));
            check("done", 32'(done), 32'(c == d));
            if (ei) begin
                last_x = qx[k];
                last_y = qy[k];
            end
            check("Xcoord", 32'(Xcoord), 32'(last_x));
            check("Ycoord", 32'(Ycoord), 32'(last_y));
            if (c >= 1) check("pixel_count", 32'(pixel_count), 32'(n_iss));
            if (c >= 2) begin
                check("Xcenter", 32'(Xcenter), 32'(s_xc));
                check("Ycenter", 32'(Ycenter), 32'(s_yc));
                check("Zoom", 32'(Zoom), 32'(s_zm));
                check("Angle", 32'(Angle), 32'(s_an));
            end
            if (done && obs_d < 0) obs_d = c;
            hist[c] = ei;
            if (ei) begin
                n_iss++;
                k++;
                last_iss = c;
            end
            if (open && c >= 1 && (n_iss == n || c == abort_cyc)) begin
                open = 1'b0;
                d = c + 2;
                if (last_iss >= 0 && last_iss + L + 1 > d) d = last_iss + L + 1;
            end
            if ((d >= 0 && c >= d + 2) || c >= 900) break;

            @(posedge ACLK); #1;
            c++;
            ARESET = (rst_cyc >= 0 && c == rst_cyc);
            if ((d < 0 || c <= d) && (rst_cyc < 0 || c < rst_cyc))
                start = 1'($urandom_range(1));
            else
                start = 1'b0;
            stall = (c >= st_lo && c <= st_hi) || ($urandom_range(99) < stall_pct);
`ifdef XFORM_SCHED_ABORT_EN
            abort = (c == abort_cyc);
`endif
            if (c >= 2) begin
                cfg_xcenter = CW'($urandom);
                cfg_ycenter = CW'($urandom);
                cfg_zoom    = CW'($urandom);
                cfg_angle   = ang0 ^ 8'h90;
                cfg_xmax    = CW'($urandom);
                cfg_ymax    = CW'($urandom);
            end
        end

        if (rst_cyc >= 0) begin
            for (int j = 0; j < 3; j++) begin
                @(posedge ACLK); #1;
                start = 1'b0;
                stall = 1'($urandom_range(1));
                @(negedge ACLK);
                check("idle_busy", 32'(busy), 32'(0));
                check("idle_done", 32'(done), 32'(0));
                check("idle_issue", 32'(issue_valid), 32'(0));
                check("idle_pix", 32'(pix_valid), 32'(0));
            end
        end else begin
            check("done_seen", 32'(obs_d >= 0), 32'(1));
            if (exp_d >= 0) check("done_cycle", 32'(obs_d), 32'(exp_d));
            if (exp_n >= 0) check("final_count", 32'(pixel_count), 32'(exp_n));
        end
        start = 1'b0;
        stall = 1'b0;
`ifdef XFORM_SCHED_ABORT_EN
        abort = 1'b0;
`endif
    endtask

    initial begin
        ARESET = 1'b1; start = 1'b0; stall = 1'b0;
        cfg_xcenter = '0; cfg_ycenter = '0; cfg_zoom = '0; cfg_angle = '0;
        cfg_xmax = '0; cfg_ymax = '0;
`ifdef XFORM_SCHED_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check_all_zero("reset");
        @(posedge ACLK); #1;
        ARESET = 1'b0;

        // Directed frames from the test plan.
        run_frame(1, 1, 0, 0, -1, -1, -1, 8'h10, 11, 4);
        run_frame(1, 1, 0, 3,  4, -1, -1, 8'h10, 13, 4);
        run_frame(0, 0, 0, 0, -1, -1, -1, 8'h10,  8, 1);
        run_frame(2, 1, 0, 0, -1, -1, -1, 8'h10, 13, 6);
        run_frame(3, 3, 0, 0, -1, -1,  4, 8'h10, -1, -1);
        run_frame(3, 3, 0, 0, -1, -1, -1, 8'h10, 23, 16);
`ifdef XFORM_SCHED_ABORT_EN
        run_frame(3, 3, 0, 0, -1, 5, -1, 8'h10, 11, 4);
        run_frame(3, 3, 0, 0, -1, 1, -1, 8'h10,  3, 0);
`endif

        // Randomized frames with random stall (and abort when available).
        for (int i = 0; i < 20; i++) begin
            int xm, ym, ab;
            xm = $urandom_range(7);
            ym = $urandom_range(5);
            ab = -1;
`ifdef XFORM_SCHED_ABORT_EN
            if ($urandom_range(1) == 1) ab = $urandom_range((xm + 1) * (ym + 1) + 3, 1);
`endif
            run_frame(xm, ym, 30, 0, -1, ab, -1, CW'($urandom), -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
